parity_frame_checker: RTL and testbench



---
 rtl/parity_frame_checker.sv | 115 +++++++++++
 tb/tb_parity_frame_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Streaming per-word parity flags plus FRAME_LEN-word frame parity check with a saturating error count.
// Optional build macro PARITY_ERR_STICKY_EN makes par_err sticky until rst_n or clear.
module parity_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              odd_mode,
  input  logic              par_in,
  output logic              word_valid,
  output logic              even,
  output logic              odd,
  output logic              frame_done,
  output logic              frame_par,
  output logic              par_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CTR_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state, state_nxt;
  logic [CTR_W-1:0] cnt, cnt_nxt;
  logic             acc, acc_nxt;

  logic accept, word_par, last, frame_bit, mismatch;

  assign accept    = in_valid & ~clear;
  assign word_par  = ^in_data;
  assign last      = accept && (cnt == LAST_IDX);
  // IDLE guarantees an empty accumulator, so the first word's parity is the running value.
  assign frame_bit = ((state == ACCUM) ? acc : 1'b0) ^ word_par;
  assign mismatch  = (frame_bit ^ odd_mode) != par_in;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every variable and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      acc_nxt   = 1'b0;
    end else if (accept) begin
      case (state)
        IDLE, ACCUM: begin
          if (last) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            acc_nxt   = 1'b0;
          end else begin
            state_nxt = ACCUM;
            cnt_nxt   = cnt + 1'b1;
            acc_nxt   = frame_bit;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      even       <= 1'b0;
      odd        <= 1'b0;
      frame_done <= 1'b0;
      frame_par  <= 1'b0;
      par_err    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      word_valid <= accept;
      frame_done <= last;
      if (accept) begin
        odd  <= word_par;
        even <= ~word_par;
      end
      if (last) begin
        frame_par <= frame_bit;
        if (mismatch && (err_cnt != {CNT_W{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end
`ifdef PARITY_ERR_STICKY_EN
      if (clear)
        par_err <= 1'b0;
      else if (last)
        par_err <= par_err | mismatch;
`else
      if (last)
        par_err <= mismatch;
`endif
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised bench for parity_frame_checker: two instances (FRAME_LEN=4/CNT_W=2 and FRAME_LEN=1/CNT_W=3)
// checked every cycle against a frame-level reference model, plus directed scenarios.
module tb_parity_frame_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, in_valid, odd_mode, par_in;
  logic [7:0] in_data;

  logic       wv_a, ev_a, od_a, fd_a, fp_a, pe_a;
  logic [1:0] ec_a;
  logic       wv_b, ev_b, od_b, fd_b, fp_b, pe_b;
  logic [2:0] ec_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  int fl   [2] = '{4, 1};
  int cmax [2] = '{3, 7};
  int m_words [2];
  int m_ones  [2];
  int m_ec    [2];
  bit m_wv [2], m_ev [2], m_od [2], m_fd [2], m_fp [2], m_pe [2];

  always #5 clk = ~clk;

  parity_frame_checker #(.DATA_W(8), .FRAME_LEN(4), .CNT_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .odd_mode(odd_mode), .par_in(par_in), .word_valid(wv_a), .even(ev_a), .odd(od_a),
    .frame_done(fd_a), .frame_par(fp_a), .par_err(pe_a), .err_cnt(ec_a)
  );

  parity_frame_checker #(.DATA_W(8), .FRAME_LEN(1), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .odd_mode(odd_mode), .par_in(par_in), .word_valid(wv_b), .even(ev_b), .odd(od_b),
    .frame_done(fd_b), .frame_par(fp_b), .par_err(pe_b), .err_cnt(ec_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_words[k] = 0; m_ones[k] = 0; m_ec[k] = 0;
      m_wv[k] = 0; m_ev[k] = 0; m_od[k] = 0; m_fd[k] = 0; m_fp[k] = 0; m_pe[k] = 0;
    end
  endtask

  // Frame-level rules: count accepted words, total their ones; a frame's parity is that total mod 2.
  task automatic model_step(input bit v, input bit c, input logic [7:0] d, input bit om, input bit pi);
    bit a, p, mis;
    a = v && !c;
    for (int k = 0; k < 2; k++) begin
      m_wv[k] = a;
      m_fd[k] = 0;
      if (a) begin
        m_od[k] = ($countones(d) % 2) == 1;
        m_ev[k] = !m_od[k];
      end
      if (c) begin
        m_words[k] = 0;
        m_ones[k]  = 0;
`ifdef PARITY_ERR_STICKY_EN
        m_pe[k] = 0;
`endif
      end else if (a) begin
        m_words[k]++;
        m_ones[k] += $countones(d);
        if (m_words[k] == fl[k]) begin
          p   = (m_ones[k] % 2) == 1;
          mis = (p ^ om) != pi;
          m_fd[k] = 1;
          m_fp[k] = p;
`ifdef PARITY_ERR_STICKY_EN
          m_pe[k] = m_pe[k] | mis;
`else
          m_pe[k] = mis;
`endif
          if (mis && m_ec[k] < cmax[k]) m_ec[k]++;
          m_words[k] = 0;
          m_ones[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input int k, input string n, input logic wv, input logic ev, input logic od,
                           input logic fd, input logic fp, input logic pe, input logic [7:0] ec);
    check({n, ".word_valid"}, 32'(wv), 32'(m_wv[k]));
    check({n, ".even"},       32'(ev), 32'(m_ev[k]));
    check({n, ".odd"},        32'(od), 32'(m_od[k]));
    check({n, ".frame_done"}, 32'(fd), 32'(m_fd[k]));
    check({n, ".frame_par"},  32'(fp), 32'(m_fp[k]));
    check({n, ".par_err"},    32'(pe), 32'(m_pe[k]));
    check({n, ".err_cnt"},    32'(ec), 32'(m_ec[k]));
  endtask

  task automatic check_all();
    check_dut(0, "a", wv_a, ev_a, od_a, fd_a, fp_a, pe_a, {6'b0, ec_a});
    check_dut(1, "b", wv_b, ev_b, od_b, fd_b, fp_b, pe_b, {5'b0, ec_b});
  endtask

  task automatic cycle(input bit v, input bit c, input logic [7:0] d, input bit om, input bit pi);
    in_valid = v; clear = c; in_data = d; odd_mode = om; par_in = pi;
    @(posedge clk);
    #1;
    model_step(v, c, d, om, pi);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; clear = 0; in_valid = 0; in_data = '0; odd_mode = 0; par_in = 0;
    #2;
    do_reset();

    // Per-word flags.
    cycle(1, 0, 8'h03, 0, 0);
    check("flags_03", {31'b0, ev_a}, 32'd1);
    cycle(1, 0, 8'h07, 0, 0);
    check("flags_07", {31'b0, od_a}, 32'd1);

    // Reset mid-frame (two words into dut_a's frame); all outputs must drop at once.
    #2;
    do_reset();
    check("rst_err_cnt", {30'b0, ec_a}, 32'd0);

    // Good frame, then bad frame, then odd-mode frame of 8'hFF words.
    for (int i = 0; i < 4; i++) cycle(1, 0, (i == 0) ? 8'h01 : 8'h00, 0, 1);
    check("good.frame_done", {31'b0, fd_a}, 32'd1);
    check("good.frame_par",  {31'b0, fp_a}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, (i == 0) ? 8'h01 : 8'h00, 0, 0);
    check("bad.par_err", {31'b0, pe_a}, 32'd1);
    check("bad.err_cnt", {30'b0, ec_a}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'hFF, 1, 1);
    check("oddmode.frame_par", {31'b0, fp_a}, 32'd0);
    check("oddmode.err_cnt",   {30'b0, ec_a}, 32'd1);

    // Gaps of three idle cycles between words; in_data garbage while idle.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 8'h5A, 0, 0);
      for (int j = 0; j < 3; j++) cycle(0, 0, 8'($urandom), 1, 1);
    end

    // Clear after two words, with in_valid on the clear cycle; next four words form a frame.
    cycle(1, 0, 8'h01, 0, 0);
    cycle(1, 0, 8'h02, 0, 0);
    cycle(1, 1, 8'h04, 0, 0);
    check("clear.word_valid", {31'b0, wv_a}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'h10, 0, 1);
    check("clear.frame_done", {31'b0, fd_a}, 32'd1);

    // Saturation: five back-to-back mismatching frames on the 2-bit counter.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 4; i++) cycle(1, 0, (i == 0) ? 8'h01 : 8'h00, 0, 0);
      check("sat.frame_done", {31'b0, fd_a}, 32'd1);
      check("sat.err_cnt", {30'b0, ec_a}, (f < 3) ? 32'(f + 1) : 32'd3);
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(9) < 7), ($urandom_range(31) == 0), 8'($urandom),
            1'($urandom), 1'($urandom));
      if (i == 1500) begin
        #2;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
